// File: rtl/kamacore_hazard_control_if.sv
// Hazard-control bus: pipeline status into the hazard unit, stage hold/clear controls out.
interface kamacore_hazard_control_if #(
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned STALL_CNT_WIDTH = 16
);
  // Pipeline status from ID/EX/MEM
  logic [REG_ADDR_WIDTH-1:0]  id_rs1;
  logic [REG_ADDR_WIDTH-1:0]  id_rs2;
  logic                       id_uses_rs1;
  logic                       id_uses_rs2;
  logic [REG_ADDR_WIDTH-1:0]  ex_destination_register;
  logic                       ex_control_memory_read;
  logic                       ex_control_write_register;
  logic                       ex_branch_taken;
  logic                       mem_req;
  logic                       mem_ready;

  // Stage-register controls and performance counter
  logic                       hold_if;
  logic                       hold_id;
  logic                       hold_ex;
  logic                       hold_mem;
  logic                       clear_id;
  logic                       clear_ex;
  logic                       clear_mem;
  logic                       clear_wb;
  logic [STALL_CNT_WIDTH-1:0] stall_count;

  // Pipeline side: drives status, consumes controls
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_destination_register, ex_control_memory_read, ex_control_write_register,
    output ex_branch_taken, mem_req, mem_ready,
    input  hold_if, hold_id, hold_ex, hold_mem,
    input  clear_id, clear_ex, clear_mem, clear_wb, stall_count
  );

  // Hazard unit side
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_destination_register, ex_control_memory_read, ex_control_write_register,
    input  ex_branch_taken, mem_req, mem_ready,
    output hold_if, hold_id, hold_ex, hold_mem,
    output clear_id, clear_ex, clear_mem, clear_wb, stall_count
  );
endinterface

// File: rtl/kamacore_hazard_control.sv
// Hold/clear generation for the IF->ID->EX->MEM->WB stage registers:
// data-memory freeze, taken-branch flush, load-use stall, and a saturating
// stall-cycle counter. Controls are combinational from state and inputs.
module kamacore_hazard_control #(
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned FLUSH_CYCLES    = 1,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  kamacore_hazard_control_if.slave hz
);

  localparam int unsigned FLUSH_CNT_W = 3;
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [FLUSH_CNT_W-1:0]     r_flush_cnt;
  logic [FLUSH_CNT_W-1:0]     w_next_flush_cnt;
  logic [STALL_CNT_WIDTH-1:0] r_stall_count;

  logic w_mem_wait;
  logic w_load_use;
  logic w_hold_if;
  logic w_hold_id;
  logic w_hold_ex;
  logic w_hold_mem;
  logic w_clear_id;
  logic w_clear_ex;
  logic w_clear_mem;
  logic w_clear_wb;

  assign w_mem_wait = hz.mem_req & ~hz.mem_ready;

  // Load in EX feeding a live source of the ID instruction; x0 never hazards
  assign w_load_use = hz.ex_control_memory_read & hz.ex_control_write_register &
                      (|hz.ex_destination_register) &
                      ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_destination_register)) |
                       (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_destination_register)));

  // State, flush counter and stall counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_flush_cnt   <= '0;
      r_stall_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_flush_cnt;
      if (w_hold_if && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + STALL_CNT_WIDTH'(1);
      end
    end
  end

  // Next state and controls; priority is mem wait > branch flush > load-use
  always_comb begin
    w_next_state     = r_state;
    w_next_flush_cnt = r_flush_cnt;
    w_hold_if        = 1'b0;
    w_hold_id        = 1'b0;
    w_hold_ex        = 1'b0;
    w_hold_mem       = 1'b0;
    w_clear_id       = 1'b0;
    w_clear_ex       = 1'b0;
    w_clear_mem      = 1'b0;
    w_clear_wb       = 1'b0;

    if (rst) begin
      w_next_state     = ST_RUN;
      w_next_flush_cnt = '0;
      w_clear_id       = 1'b1;
      w_clear_ex       = 1'b1;
      w_clear_mem      = 1'b1;
      w_clear_wb       = 1'b1;
    end else if (w_mem_wait) begin
      // Freeze everything up to MEM; the flush countdown is parked
      w_hold_if    = 1'b1;
      w_hold_id    = 1'b1;
      w_hold_ex    = 1'b1;
      w_hold_mem   = 1'b1;
      w_clear_wb   = 1'b1;
      w_next_state = ST_MEM_WAIT;
    end else begin
      unique case (r_state)
        ST_MEM_WAIT: begin
          // Access completes: let the pipeline advance, resume any parked flush
          w_next_state = (r_flush_cnt != '0) ? ST_FLUSH : ST_RUN;
        end
        ST_RUN, ST_FLUSH: begin
          if (hz.ex_branch_taken) begin
            w_clear_id = 1'b1;
            w_clear_ex = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_next_flush_cnt = FLUSH_RELOAD;
              w_next_state     = ST_FLUSH;
            end else begin
              w_next_flush_cnt = '0;
              w_next_state     = ST_RUN;
            end
          end else if (r_state == ST_FLUSH) begin
            // ID holds a bubble here, so no load-use check
            w_clear_id = 1'b1;
            if (r_flush_cnt != '0) begin
              w_next_flush_cnt = r_flush_cnt - FLUSH_CNT_W'(1);
            end
            if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
              w_next_state = ST_RUN;
            end
          end else if (w_load_use) begin
            w_hold_if  = 1'b1;
            w_hold_id  = 1'b1;
            w_clear_ex = 1'b1;
          end
        end
        default: begin
          w_next_state     = ST_RUN;
          w_next_flush_cnt = '0;
        end
      endcase
    end
  end

  assign hz.hold_if     = w_hold_if;
  assign hz.hold_id     = w_hold_id;
  assign hz.hold_ex     = w_hold_ex;
  assign hz.hold_mem    = w_hold_mem;
  assign hz.clear_id    = w_clear_id;
  assign hz.clear_ex    = w_clear_ex;
  assign hz.clear_mem   = w_clear_mem;
  assign hz.clear_wb    = w_clear_wb;
  assign hz.stall_count = r_stall_count;

endmodule
